// File: rtl/wordle_guess_scorer_if.sv
// Guess-entry / LED-driver side signals of the Wordle guess scorer.
interface wordle_guess_scorer_if;
    logic        new_game;
    logic        start;
    logic [24:0] guess;
    logic [24:0] answer;
    logic [2:0]  led1;
    logic [2:0]  led2;
    logic [2:0]  led3;
    logic [2:0]  led4;
    logic [2:0]  led5;
    logic [1:0]  state;
    logic        warning;
    logic        busy;
    logic        done;

    modport master (
        output new_game, start, guess, answer,
        input  led1, led2, led3, led4, led5, state, warning, busy, done
    );

    modport slave (
        input  new_game, start, guess, answer,
        output led1, led2, led3, led4, led5, state, warning, busy, done
    );
endinterface

// File: rtl/wordle_guess_scorer.sv
// Wordle guess scorer: one letter position per cycle, first counting the
// unmatched answer letters, then marking each guess letter green/yellow/grey
// left to right so duplicate letters are handled exactly like the game.
module wordle_guess_scorer #(
    parameter int MAX_TRIES = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    wordle_guess_scorer_if.slave         bus
);
    localparam logic [2:0] MAX_T   = 3'(MAX_TRIES);
    localparam logic [2:0] GREEN   = 3'b100;
    localparam logic [2:0] YELLOW  = 3'b010;
    localparam logic [2:0] GREY    = 3'b001;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_WON  = 2'd2;
    localparam logic [1:0] ST_LOST = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_MARK} fsm_t;

    // Letter i (0 = leftmost) of a packed 5-letter word.
    function automatic logic [4:0] letter_at(input logic [24:0] w, input logic [2:0] i);
        case (i)
            3'd0:    return w[24:20];
            3'd1:    return w[19:15];
            3'd2:    return w[14:10];
            3'd3:    return w[9:5];
            default: return w[4:0];
        endcase
    endfunction

    function automatic logic all_valid(input logic [24:0] w);
        for (int k = 0; k < 5; k++)
            if (letter_at(w, 3'(k)) > 5'd25) return 1'b0;
        return 1'b1;
    endfunction

    fsm_t        fsm_q, fsm_d;
    logic [2:0]  idx_q, idx_d;
    logic [24:0] guess_q, guess_d;
    logic [24:0] answer_q, answer_d;
    logic [2:0]  cnt_q [26];
    logic [2:0]  cnt_d [26];
    logic [2:0]  scratch_q [5];
    logic [2:0]  scratch_d [5];
    logic [2:0]  led_q [5];
    logic [2:0]  led_d [5];
    logic [1:0]  state_q, state_d;
    logic        warning_q, warning_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [2:0]  attempts_q, attempts_d;

    logic [4:0]  cur_g, cur_a;
    logic [2:0]  att_inc;
    logic        win;

    assign cur_g   = letter_at(guess_q, idx_q);
    assign cur_a   = letter_at(answer_q, idx_q);
    assign att_inc = (attempts_q == MAX_T) ? attempts_q : attempts_q + 3'd1;

    assign bus.led1    = led_q[0];
    assign bus.led2    = led_q[1];
    assign bus.led3    = led_q[2];
    assign bus.led4    = led_q[3];
    assign bus.led5    = led_q[4];
    assign bus.state   = state_q;
    assign bus.warning = warning_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

    // Next-state: new_game first, then start acceptance, count pass, mark pass.
    always_comb begin
        fsm_d      = fsm_q;
        idx_d      = idx_q;
        guess_d    = guess_q;
        answer_d   = answer_q;
        cnt_d      = cnt_q;
        scratch_d  = scratch_q;
        led_d      = led_q;
        state_d    = state_q;
        warning_d  = warning_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        attempts_d = attempts_q;
        win        = 1'b1;

        if (bus.new_game) begin
            attempts_d = 3'd0;
            state_d    = ST_PLAY;
            led_d      = '{default: GREY};
            warning_d  = 1'b0;
            busy_d     = 1'b0;
            fsm_d      = S_IDLE;
            idx_d      = 3'd0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (bus.start && state_q == ST_PLAY) begin
                        if (all_valid(bus.guess)) begin
                            guess_d   = bus.guess;
                            answer_d  = bus.answer;
                            cnt_d     = '{default: 3'd0};
                            warning_d = 1'b0;
                            busy_d    = 1'b1;
                            fsm_d     = S_COUNT;
                            idx_d     = 3'd0;
                        end else begin
                            warning_d = 1'b1;
                        end
                    end
                end
                S_COUNT: begin
                    // Only answer letters not matched in place can earn a yellow.
                    if (cur_g != cur_a)
                        cnt_d[cur_a] = cnt_q[cur_a] + 3'd1;
                    if (idx_q == 3'd4) begin
                        fsm_d = S_MARK;
                        idx_d = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                S_MARK: begin
                    if (cur_g == cur_a) begin
                        scratch_d[idx_q] = GREEN;
                    end else if (cnt_q[cur_g] != 3'd0) begin
                        scratch_d[idx_q] = YELLOW;
                        cnt_d[cur_g]     = cnt_q[cur_g] - 3'd1;
                    end else begin
                        scratch_d[idx_q] = GREY;
                    end
                    if (idx_q == 3'd4) begin
                        for (int k = 0; k < 5; k++)
                            if (scratch_d[k] != GREEN) win = 1'b0;
                        led_d      = scratch_d;
                        attempts_d = att_inc;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        fsm_d      = S_IDLE;
                        idx_d      = 3'd0;
                        if (win)                   state_d = ST_WON;
                        else if (att_inc == MAX_T) state_d = ST_LOST;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                default: begin
                    fsm_d = S_IDLE;
                    idx_d = 3'd0;
                end
            endcase
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= S_IDLE;
            idx_q      <= 3'd0;
            guess_q    <= '0;
            answer_q   <= '0;
            cnt_q      <= '{default: 3'd0};
            scratch_q  <= '{default: GREY};
            led_q      <= '{default: GREY};
            state_q    <= ST_IDLE;
            warning_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            attempts_q <= 3'd0;
        end else begin
            fsm_q      <= fsm_d;
            idx_q      <= idx_d;
            guess_q    <= guess_d;
            answer_q   <= answer_d;
            cnt_q      <= cnt_d;
            scratch_q  <= scratch_d;
            led_q      <= led_d;
            state_q    <= state_d;
            warning_q  <= warning_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            attempts_q <= attempts_d;
        end
    end

    // ST_LOST is reached only through the attempts comparison above.
    logic unused_lost;
    assign unused_lost = (ST_LOST == 2'd3);
endmodule

// File: tb/tb_wordle_guess_scorer.sv
// Self-checking bench for wordle_guess_scorer using a result scoreboard.
module tb_wordle_guess_scorer;
    localparam int MAX_TRIES = 6;
    localparam logic [24:0] APPLE = {5'd0, 5'd15, 5'd15, 5'd11, 5'd4};
    localparam logic [24:0] PAPER = {5'd15, 5'd0, 5'd15, 5'd4, 5'd17};
    localparam logic [24:0] PPPPP = {5{5'd15}};
    localparam logic [24:0] ZZZZZ = {5{5'd25}};
    localparam logic [24:0] BADW  = {5'd0, 5'd15, 5'd27, 5'd11, 5'd4};
    localparam logic [14:0] ALL_GREY  = {5{3'b001}};
    localparam logic [14:0] ALL_GREEN = {5{3'b100}};

    typedef struct {
        logic [14:0] leds;
        logic [1:0]  st;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wordle_guess_scorer_if bus();
    wordle_guess_scorer #(.MAX_TRIES(MAX_TRIES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          tb_attempts = 0;
    logic [14:0] last_leds = ALL_GREY;

    function automatic logic [14:0] model_leds(input logic [24:0] g, input logic [24:0] a);
        logic [4:0] gl[5];
        logic [4:0] al[5];
        logic       used[5];
        logic [2:0] r[5];
        for (int i = 0; i < 5; i++) begin
            gl[i] = g[24-5*i -: 5];
            al[i] = a[24-5*i -: 5];
            used[i] = 1'b0;
            r[i] = 3'b001;
        end
        for (int i = 0; i < 5; i++)
            if (gl[i] == al[i]) begin r[i] = 3'b100; used[i] = 1'b1; end
        for (int i = 0; i < 5; i++) begin
            if (r[i] != 3'b100) begin
                for (int j = 0; j < 5; j++) begin
                    if (!used[j] && al[j] == gl[i]) begin
                        used[j] = 1'b1;
                        r[i] = 3'b010;
                        break;
                    end
                end
            end
        end
        return {r[0], r[1], r[2], r[3], r[4]};
    endfunction

    function automatic logic [14:0] dut_leds();
        return {bus.led1, bus.led2, bus.led3, bus.led4, bus.led5};
    endfunction

    task automatic watch(input int n, output int busy_seen, output int done_seen);
        busy_seen = 0;
        done_seen = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (bus.busy) busy_seen++;
            if (bus.done) done_seen++;
        end
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        tb_attempts = 0;
        last_leds = ALL_GREY;
    endtask

    // Issue one valid start, push the expected result, wait for done, compare.
    task automatic score(input logic [24:0] g, input string name);
        exp_t e;
        exp_t got;
        int   lat;
        int   busy_cnt;
        e.leds = model_leds(g, bus.answer);
        if (tb_attempts < MAX_TRIES) tb_attempts++;
        if (e.leds == ALL_GREEN)            e.st = 2'd2;
        else if (tb_attempts == MAX_TRIES)  e.st = 2'd3;
        else                                e.st = 2'd1;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b1;
        bus.guess = g;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin lat = k - 1; break; end
        end
        got = sb.pop_front();
        n_checks++;
        if (lat < 0) begin
            n_fail++;
            $display("FAIL %s done_timeout: no done within 20 cycles, required at 10", name);
        end else begin
            if (lat != 10) begin
                n_fail++;
                $display("FAIL %s latency: got %0d required 10", name, lat);
            end
            n_checks++;
            if (busy_cnt != 10) begin
                n_fail++;
                $display("FAIL %s busy_cycles: got %0d required 10", name, busy_cnt);
            end
            n_checks++;
            if (dut_leds() !== got.leds) begin
                n_fail++;
                $display("FAIL %s leds: got %b required %b", name, dut_leds(), got.leds);
            end
            n_checks++;
            if (bus.state !== got.st) begin
                n_fail++;
                $display("FAIL %s state: got %0d required %0d", name, bus.state, got.st);
            end
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s done_pulse: got %b required 0 one cycle later", name, bus.done);
            end
        end
        last_leds = got.leds;
    endtask

    task automatic test_reset();
        int bs, ds;
        rst_n = 1'b0;
        bus.new_game = 1'b0;
        bus.start = 1'b0;
        bus.guess = '0;
        bus.answer = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dut_leds() !== ALL_GREY) begin
            n_fail++; $display("FAIL reset_leds: got %b required %b", dut_leds(), ALL_GREY);
        end
        n_checks++;
        if ({bus.state, bus.warning, bus.busy, bus.done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: state/warn/busy/done got %b required 00000",
                     {bus.state, bus.warning, bus.busy, bus.done});
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.guess = BADW;
        @(negedge clk);
        bus.start = 1'b0;
        watch(12, bs, ds);
        n_checks++;
        if (bs != 0 || ds != 0 || bus.warning !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_start_ignored: busy %0d done %0d warning %b required 0 0 0",
                     bs, ds, bus.warning);
        end
    endtask

    task automatic test_paper();
        pulse_new_game();
        bus.answer = APPLE;
        score(PAPER, "paper");
        n_checks++;
        if (dut_leds() !== 15'b010_010_100_010_001) begin
            n_fail++; $display("FAIL paper_const: got %b required 010010100010001", dut_leds());
        end
    endtask

    task automatic test_duplicates();
        score(PPPPP, "ppppp");
        n_checks++;
        if (dut_leds() !== 15'b001_100_100_001_001) begin
            n_fail++; $display("FAIL ppppp_const: got %b required 001100100001001", dut_leds());
        end
    endtask

    task automatic test_win();
        int bs, ds;
        pulse_new_game();
        bus.answer = APPLE;
        score(APPLE, "win");
        @(negedge clk);
        bus.start = 1'b1;
        bus.guess = PAPER;
        @(negedge clk);
        bus.start = 1'b0;
        watch(12, bs, ds);
        n_checks++;
        if (bs != 0 || ds != 0) begin
            n_fail++; $display("FAIL won_start_ignored: busy %0d done %0d required 0 0", bs, ds);
        end
        n_checks++;
        if (dut_leds() !== ALL_GREEN || bus.state !== 2'd2) begin
            n_fail++;
            $display("FAIL won_hold: leds %b state %0d required %b 2", dut_leds(), bus.state, ALL_GREEN);
        end
    endtask

    task automatic test_loss();
        int bs, ds;
        pulse_new_game();
        bus.answer = APPLE;
        for (int i = 1; i <= MAX_TRIES; i++) score(ZZZZZ, $sformatf("loss_try%0d", i));
        n_checks++;
        if (bus.state !== 2'd3) begin
            n_fail++; $display("FAIL loss_state: got %0d required 3", bus.state);
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.guess = BADW;
        @(negedge clk);
        bus.start = 1'b0;
        watch(12, bs, ds);
        n_checks++;
        if (bs != 0 || ds != 0 || bus.warning !== 1'b0 || bus.state !== 2'd3) begin
            n_fail++;
            $display("FAIL lost_start_ignored: busy %0d done %0d warn %b state %0d required 0 0 0 3",
                     bs, ds, bus.warning, bus.state);
        end
    endtask

    task automatic test_invalid();
        int bs, ds;
        pulse_new_game();
        bus.answer = APPLE;
        score(PAPER, "pre_invalid");
        @(negedge clk);
        bus.start = 1'b1;
        bus.guess = BADW;
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++;
        if (bus.warning !== 1'b1) begin
            n_fail++; $display("FAIL warning_set: got %b required 1", bus.warning);
        end
        watch(12, bs, ds);
        n_checks++;
        if (bs != 0 || ds != 0 || dut_leds() !== last_leds || bus.warning !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_no_score: busy %0d done %0d leds %b warn %b required 0 0 %b 1",
                     bs, ds, dut_leds(), bus.warning, last_leds);
        end
        score(PPPPP, "post_invalid");
        n_checks++;
        if (bus.warning !== 1'b0) begin
            n_fail++; $display("FAIL warning_clear: got %b required 0", bus.warning);
        end
    endtask

    task automatic test_back_to_back();
        logic [24:0] ans;
        logic [24:0] g;
        pulse_new_game();
        for (int i = 0; i < 5; i++) ans[24-5*i -: 5] = 5'($urandom_range(0, 25));
        bus.answer = ans;
        for (int t = 0; t < 5; t++) begin
            do begin
                for (int i = 0; i < 5; i++)
                    g[24-5*i -: 5] = ans[24-5*$urandom_range(0, 4) -: 5];
            end while (g == ans);
            score(g, $sformatf("b2b_%0d", t));
        end
    endtask

    task automatic test_abort();
        int bs, ds;
        pulse_new_game();
        bus.answer = APPLE;
        score(PAPER, "pre_abort");
        @(negedge clk);
        bus.start = 1'b1;
        bus.guess = PPPPP;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        tb_attempts = 0;
        n_checks++;
        if (bus.busy !== 1'b0 || dut_leds() !== ALL_GREY || bus.state !== 2'd1) begin
            n_fail++;
            $display("FAIL abort_newgame: busy %b leds %b state %0d required 0 %b 1",
                     bus.busy, dut_leds(), bus.state, ALL_GREY);
        end
        watch(15, bs, ds);
        n_checks++;
        if (bs != 0 || ds != 0) begin
            n_fail++; $display("FAIL abort_no_done: busy %0d done %0d required 0 0", bs, ds);
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.guess = PAPER;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || dut_leds() !== ALL_GREY || bus.state !== 2'd0) begin
            n_fail++;
            $display("FAIL abort_reset: busy %b leds %b state %0d required 0 %b 0",
                     bus.busy, dut_leds(), bus.state, ALL_GREY);
        end
        @(negedge clk);
        rst_n = 1'b1;
        watch(15, bs, ds);
        n_checks++;
        if (bs != 0 || ds != 0 || bus.state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_no_done: busy %0d done %0d state %0d required 0 0 0", bs, ds, bus.state);
        end
    endtask

    initial begin
        test_reset();
        test_paper();
        test_duplicates();
        test_win();
        test_loss();
        test_invalid();
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
